// File: rtl/result_bus_arbiter.sv
// Round-robin arbiter that grants up to BUS_COUNT ready stations per cycle onto
// registered result broadcast buses. The scan starts at ptr and wraps.
module result_bus_arbiter #(
  parameter int SIZE               = 32,
  parameter int STATION_COUNT      = 4,
  parameter int STATION_INDEX_SIZE = 2,
  parameter int BUS_COUNT          = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          station_ready   [STATION_COUNT],
  input  logic [SIZE-1:0]               station_result  [STATION_COUNT],
  output logic                          station_release [STATION_COUNT],
  output logic                          bus_asserted    [BUS_COUNT],
  output logic [STATION_INDEX_SIZE-1:0] bus_source      [BUS_COUNT],
  output logic [SIZE-1:0]               bus_value       [BUS_COUNT]
);

  logic [STATION_INDEX_SIZE-1:0] ptr_q, ptr_d;
  logic                          release_q  [STATION_COUNT];
  logic                          release_d  [STATION_COUNT];
  logic                          asserted_q [BUS_COUNT];
  logic                          asserted_d [BUS_COUNT];
  logic [STATION_INDEX_SIZE-1:0] source_q   [BUS_COUNT];
  logic [STATION_INDEX_SIZE-1:0] source_d   [BUS_COUNT];
  logic [SIZE-1:0]               value_q    [BUS_COUNT];
  logic [SIZE-1:0]               value_d    [BUS_COUNT];

  logic eligible [STATION_COUNT];
  int   scan_pos [STATION_COUNT];
  int   rank     [STATION_COUNT];
  int   last_pos;

  // scan_pos is a station's distance from ptr in scan order; rank counts the
  // eligible stations ahead of it, so rank < BUS_COUNT means "selected".
  always_comb begin
    for (int s = 0; s < STATION_COUNT; s++) begin
      eligible[s] = station_ready[s] && !release_q[s];
      scan_pos[s] = s - int'(ptr_q);
      if (scan_pos[s] < 0) scan_pos[s] = scan_pos[s] + STATION_COUNT;
    end
    for (int s = 0; s < STATION_COUNT; s++) begin
      rank[s] = 0;
      for (int t = 0; t < STATION_COUNT; t++) begin
        if (eligible[t] && (scan_pos[t] < scan_pos[s])) rank[s] = rank[s] + 1;
      end
    end
  end

  always_comb begin
    ptr_d    = ptr_q;
    last_pos = -1;
    for (int s = 0; s < STATION_COUNT; s++) release_d[s] = 1'b0;
    for (int b = 0; b < BUS_COUNT; b++) begin
      asserted_d[b] = 1'b0;
      source_d[b]   = '0;
      value_d[b]    = '0;
    end
    if (!flush) begin
      for (int s = 0; s < STATION_COUNT; s++) begin
        if (eligible[s] && (rank[s] < BUS_COUNT)) begin
          release_d[s] = 1'b1;
          // ptr follows the selected station that is furthest along the scan
          if (scan_pos[s] > last_pos) begin
            last_pos = scan_pos[s];
            ptr_d    = (s == STATION_COUNT - 1) ? '0 : STATION_INDEX_SIZE'(s + 1);
          end
        end
        for (int b = 0; b < BUS_COUNT; b++) begin
          if (eligible[s] && (rank[s] == b)) begin
            asserted_d[b] = 1'b1;
            source_d[b]   = STATION_INDEX_SIZE'(s);
            value_d[b]    = station_result[s];
          end
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
      for (int s = 0; s < STATION_COUNT; s++) release_q[s] <= 1'b0;
      for (int b = 0; b < BUS_COUNT; b++) begin
        asserted_q[b] <= 1'b0;
        source_q[b]   <= '0;
        value_q[b]    <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      for (int s = 0; s < STATION_COUNT; s++) release_q[s] <= release_d[s];
      for (int b = 0; b < BUS_COUNT; b++) begin
        asserted_q[b] <= asserted_d[b];
        source_q[b]   <= source_d[b];
        value_q[b]    <= value_d[b];
      end
    end
  end

  for (genvar gi = 0; gi < STATION_COUNT; gi++) begin : g_release
    assign station_release[gi] = release_q[gi];
  end

  for (genvar gi = 0; gi < BUS_COUNT; gi++) begin : g_bus
    assign bus_asserted[gi] = asserted_q[gi];
    assign bus_source[gi]   = source_q[gi];
    assign bus_value[gi]    = value_q[gi];
  end

endmodule
